// File: rtl/uart_pkg.sv
// uart_pkg: shared parity codes, tx state encoding and baud-counter sizing helpers.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction
  function automatic int cnt_width(input int cnt);
    return (cnt <= 2) ? 1 : $clog2(cnt);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: generic synchronous FIFO with full/empty/level flags.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
  end
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: buffered UART transmitter, back-to-back frames while data is queued.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int CW      = cnt_width(BPS_CNT);
  if (BPS_CNT < 2) begin : g_bad_bps
    $error("uart_tx_fifo_param: CLK_FREQ/UART_BPS must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
    $error("uart_tx_fifo_param: DATA_BITS must be 5..8");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
    $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  tx_state_e            state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic                 par_q, par_d, txd_q, txd_d;
  logic                 full, empty, pop, load, bit_end, unused_ok;
  assign unused_ok = ^tx_data;
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .push_i  (tx_valid && tx_ready),
    .wdata_i (tx_data[DATA_BITS-1:0]),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );
  assign tx_ready     = !full;
  assign uart_txd     = txd_q;
  assign uart_tx_busy = state_q != ST_IDLE || !empty;
  assign bit_end      = clk_cnt_q == CW'(BPS_CNT - 1);
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = (state_q == ST_IDLE || bit_end) ? '0 : clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    txd_d     = txd_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE:   load = !empty;
      ST_START:  if (bit_end) begin
        state_d   = ST_DATA;
        txd_d     = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
      end
      ST_DATA:   if (bit_end) begin
        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
          state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          txd_d     = (PARITY != PAR_NONE) ? par_q : 1'b1;
          bit_cnt_d = '0;
        end else begin
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d   = ST_STOP;
        txd_d     = 1'b1;
        bit_cnt_d = '0;
      end
      ST_STOP:   if (bit_end) begin
        if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
          state_d = ST_IDLE;
          load    = !empty;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    // Reloading straight from STOP keeps consecutive frames gapless.
    if (load) begin
      state_d   = ST_START;
      txd_d     = 1'b0;
      shift_d   = head;
      par_d     = (^head) ^ (PARITY == PAR_ODD);
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end
    pop = load;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
    end
  end
endmodule
